// File: rtl/frame_dbuf_mux_pkg.sv
// ----------------------------------------------------------------------------
// frame_dbuf_mux_pkg : mode/pattern codes and voxel pattern rule for the frame store
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package frame_dbuf_mux_pkg;

  localparam logic [1:0] c_mode_live    = 2'd0;
  localparam logic [1:0] c_mode_pat     = 2'd1;

  localparam logic [3:0] c_pat_all      = 4'h0;
  localparam logic [3:0] c_pat_zlayer   = 4'h1;
  localparam logic [3:0] c_pat_yplane   = 4'h9;
  localparam logic [3:0] c_pat_xplane   = 4'hc;
  localparam logic [3:0] c_pat_edge     = 4'hf;

  // One voxel of test pattern p; edges are voxels with >=2 coordinates on a face
  function automatic logic pattern_voxel(input int n, input logic [3:0] p,
                                         input int x, input int y, input int z);
    int   ends;
    int   pi;
    logic r;
    ends = 0;
    pi   = int'(p);
    if (x == 0 || x == n - 1) ends = ends + 1;
    if (y == 0 || y == n - 1) ends = ends + 1;
    if (z == 0 || z == n - 1) ends = ends + 1;
    r = 1'b0;
    if (p == c_pat_all)         r = 1'b1;
    else if (p < c_pat_yplane)  r = (z == (pi - int'(c_pat_zlayer)) % n);
    else if (p < c_pat_xplane)  r = (y == (pi - int'(c_pat_yplane)) % n);
    else if (p < c_pat_edge)    r = (x == (pi - int'(c_pat_xplane)) % n);
    else                        r = (ends >= 2);
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/frame_dbuf_mux_pattern_gen.sv
// ----------------------------------------------------------------------------
// cube_pattern_gen : combinational pat_sel -> full-cube test pattern
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cube_pattern_gen
  import frame_dbuf_mux_pkg::*;
#(
  parameter int CUBE_N = 8
) (
  input  logic [3:0]                    pat_sel,
  output logic [CUBE_N*CUBE_N*CUBE_N-1:0] pattern
);

  for (genvar z = 0; z < CUBE_N; z++) begin : g_z
    for (genvar y = 0; y < CUBE_N; y++) begin : g_y
      for (genvar x = 0; x < CUBE_N; x++) begin : g_x
        assign pattern[z*CUBE_N*CUBE_N + y*CUBE_N + x] =
          pattern_voxel(CUBE_N, pat_sel, x, y, z);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/frame_dbuf_mux.sv
// ----------------------------------------------------------------------------
// frame_dbuf_mux : double-buffered tear-free cube frame store with source mux
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module frame_dbuf_mux
  import frame_dbuf_mux_pkg::*;
#(
  parameter  int CUBE_N    = 8,
  parameter  int NUM_SRC   = 2,
  parameter  int CNT_W     = 32,
  parameter  int OVERWRITE = 1,
  localparam int FRAME_W   = CUBE_N * CUBE_N * CUBE_N,
  localparam int SRC_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 mode,
  input  logic [SRC_W-1:0]           src_sel,
  input  logic [3:0]                 pat_sel,
  input  logic [NUM_SRC*FRAME_W-1:0] src_frame_flat,
  input  logic [NUM_SRC-1:0]         src_valid,
  output logic [NUM_SRC-1:0]         src_ready,
  input  logic                       scan_done,
  output logic [FRAME_W-1:0]         frame_cube_flat,
  output logic                       pending,
  output logic                       sync,
  output logic [CNT_W-1:0]           frame_cnt,
  output logic [CNT_W-1:0]           drop_cnt
);

  logic [FRAME_W-1:0] r_front;
  logic [FRAME_W-1:0] r_back;
  logic               r_pending;
  logic               r_sync;
  logic [CNT_W-1:0]   r_frame_cnt;
  logic [CNT_W-1:0]   r_drop_cnt;

  logic [FRAME_W-1:0] w_frames [NUM_SRC];
  logic [FRAME_W-1:0] w_pattern;
  logic               w_live;
  logic               w_pat;
  logic               w_sel_ok;
  logic               w_sel_ready;
  logic               w_accept;
  logic               w_swap;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign w_frames[i] = src_frame_flat[i*FRAME_W +: FRAME_W];
    // Unselected sources are drained so producers never stall on them
    assign src_ready[i] = w_live ? ((src_sel == SRC_W'(i)) ? w_sel_ready : 1'b1)
                                 : w_pat;
  end

  cube_pattern_gen #(
    .CUBE_N (CUBE_N)
  ) u_pattern (
    .pat_sel (pat_sel),
    .pattern (w_pattern)
  );

  assign w_live      = (mode == c_mode_live);
  assign w_pat       = (mode == c_mode_pat);
  assign w_sel_ok    = (int'(src_sel) < NUM_SRC);
  assign w_sel_ready = (OVERWRITE != 0) ? 1'b1 : !r_pending;
  assign w_accept    = w_live && w_sel_ok && src_valid[src_sel] && w_sel_ready;
  assign w_swap      = w_live && scan_done && r_pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_front     <= '0;
      r_back      <= '0;
      r_pending   <= 1'b0;
      r_sync      <= 1'b0;
      r_frame_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      r_sync <= w_swap;
      if (w_live) begin
        // Front takes the old back contents even when a new frame lands this cycle
        if (w_swap) begin
          r_front     <= r_back;
          r_frame_cnt <= r_frame_cnt + CNT_W'(1);
        end
        if (w_accept) begin
          r_back <= w_frames[src_sel];
          if (r_pending && !w_swap) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
        end
        r_pending <= w_accept || (r_pending && !w_swap);
      end else if (w_pat) begin
        r_pending <= 1'b0;
        if (scan_done) r_front <= w_pattern;
      end
    end
  end

  assign frame_cube_flat = r_front;
  assign pending         = r_pending;
  assign sync            = r_sync;
  assign frame_cnt       = r_frame_cnt;
  assign drop_cnt        = r_drop_cnt;

endmodule

`default_nettype wire
